// File: rtl/ula_pkg.sv
// Shared constants for the ula arbiter: ula opcode map and FSM state encoding.
package ula_pkg;

  localparam logic [3:0] OP_SOMA  = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MULT  = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_NAND  = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1000;
  localparam logic [3:0] OP_XNOR  = 4'b1001;
  localparam logic [3:0] OP_NOT   = 4'b1010;
  localparam logic [3:0] OP_SHL   = 4'b1011;
  localparam logic [3:0] OP_SHR   = 4'b1100;
  localparam logic [3:0] OP_MAIOR = 4'b1101;
  localparam logic [3:0] OP_MENOR = 4'b1110;
  localparam logic [3:0] OP_IGUAL = 4'b1111;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_EXEC = 1'b1;

endpackage

// File: rtl/ula_arbitro_arb_rr.sv
// Combinational round-robin picker: first set req bit after index 'last', wrapping mod N.
module arb_rr #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    // Offsets 1..N visit last+1 first and last itself at the very end.
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last) + i) % N;
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = IW'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ula_arbitro.sv
// Round-robin arbiter sharing one external combinational ula between NREQ requesters.
module ula_arbitro #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] op_in,
  input  logic [4*NREQ-1:0] a_in,
  input  logic [4*NREQ-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   resp_valid,
  output logic [1:0]        resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic [3:0]        ula_switchs,
  output logic [3:0]        ula_a,
  output logic [3:0]        ula_b,
  input  logic [1:0]        ula_saida
);

  import ula_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [1:0]      resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;
  logic            busy_q, busy_d;
  logic [3:0]      ula_sw_q, ula_sw_d;
  logic [3:0]      ula_a_q, ula_a_d;
  logic [3:0]      ula_b_q, ula_b_d;

  logic [NREQ-1:0] win_onehot;
  logic [IW-1:0]   win_idx;
  logic            win_any;

  arb_rr #(.N(NREQ), .IW(IW)) u_arb (
    .req    (req),
    .last   (last_q),
    .onehot (win_onehot),
    .idx    (win_idx),
    .any    (win_any)
  );

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    busy_d       = busy_q;
    ula_sw_d     = ula_sw_q;
    ula_a_d      = ula_a_q;
    ula_b_d      = ula_b_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d        = '0;
        resp_valid_d = '0;
        if (win_any) begin
          ula_sw_d = op_in[4*int'(win_idx) +: 4];
          ula_a_d  = a_in[4*int'(win_idx) +: 4];
          ula_b_d  = b_in[4*int'(win_idx) +: 4];
          gnt_d    = win_onehot;
          last_d   = win_idx;
          busy_d   = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      default: begin
        // gnt_q still holds the winner's one-hot, so it doubles as the response select.
        resp_valid_d = gnt_q;
        gnt_d        = '0;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
        if (ula_sw_q == OP_DIV && ula_b_q == 4'd0) begin
          resp_data_d = 2'b00;
          resp_err_d  = 1'b1;
        end else begin
          resp_data_d = ula_saida;
          resp_err_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= IW'(NREQ - 1);
      gnt_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= 2'b00;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      ula_sw_q     <= 4'd0;
      ula_a_q      <= 4'd0;
      ula_b_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      ula_sw_q     <= ula_sw_d;
      ula_a_q      <= ula_a_d;
      ula_b_q      <= ula_b_d;
    end
  end

  assign gnt         = gnt_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
  assign busy        = busy_q;
  assign ula_switchs = ula_sw_q;
  assign ula_a       = ula_a_q;
  assign ula_b       = ula_b_q;

endmodule

// File: tb/tb_ula_arbitro.sv
// Directed bench for ula_arbitro with NREQ=2 and a behavioural ula driving ula_saida.
module tb_ula_arbitro;

  import ula_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [7:0] op_in, a_in, b_in;
  logic [1:0] gnt, resp_valid, resp_data, ula_saida;
  logic       resp_err, busy;
  logic [3:0] ula_switchs, ula_a, ula_b;

  int n_compared   = 0;
  int n_mismatched = 0;

  ula_arbitro #(.NREQ(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .op_in       (op_in),
    .a_in        (a_in),
    .b_in        (b_in),
    .gnt         (gnt),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .busy        (busy),
    .ula_switchs (ula_switchs),
    .ula_a       (ula_a),
    .ula_b       (ula_b),
    .ula_saida   (ula_saida)
  );

  // Behavioural stand-in for the ula the parent would instantiate: low two bits of each result.
  function automatic logic [1:0] ula_model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] r;
    case (op)
      OP_SOMA:  r = {4'd0, a + b};
      OP_SUB:   r = {4'd0, a - b};
      OP_MULT:  r = a * b;
      OP_DIV:   r = (b == 4'd0) ? 8'h03 : {4'd0, a / b};
      OP_AND:   r = {4'd0, a & b};
      OP_OR:    r = {4'd0, a | b};
      OP_XOR:   r = {4'd0, a ^ b};
      OP_NAND:  r = {4'd0, ~(a & b)};
      OP_NOR:   r = {4'd0, ~(a | b)};
      OP_XNOR:  r = {4'd0, ~(a ^ b)};
      OP_NOT:   r = {4'd0, ~a};
      OP_SHL:   r = {4'd0, a << b};
      OP_SHR:   r = {4'd0, a >> b};
      OP_MAIOR: r = {7'd0, a > b};
      OP_MENOR: r = {7'd0, a < b};
      default:  r = {7'd0, a == b};
    endcase
    return r[1:0];
  endfunction

  assign ula_saida = ula_model(ula_switchs, ula_a, ula_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] r,
                               input logic [3:0] o0, input logic [3:0] a0, input logic [3:0] b0,
                               input logic [3:0] o1, input logic [3:0] a1, input logic [3:0] b1);
    req   = r;
    op_in = {o1, o0};
    a_in  = {a1, a0};
    b_in  = {b1, b0};
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset held with both requesters asking
    rst = 1'b1;
    applyStimulus(2'b11, 4'b1000, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0010);
    tick();
    tick();
    checkOutput("rst_gnt", 8'(gnt), 8'h00);
    checkOutput("rst_resp_valid", 8'(resp_valid), 8'h00);
    checkOutput("rst_resp_data", 8'(resp_data), 8'h00);
    checkOutput("rst_resp_err", 8'(resp_err), 8'h00);
    checkOutput("rst_busy", 8'(busy), 8'h00);
    checkOutput("rst_ula_sw", 8'(ula_switchs), 8'h00);
    checkOutput("rst_ula_a", 8'(ula_a), 8'h00);
    checkOutput("rst_ula_b", 8'(ula_b), 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // First grant after reset goes to requester 0
    tick();
    checkOutput("t1_gnt", 8'(gnt), 8'h01);
    checkOutput("t1_busy", 8'(busy), 8'h01);
    checkOutput("t1_ula_sw", 8'(ula_switchs), 8'h08);
    checkOutput("t1_ula_a", 8'(ula_a), 8'h0f);
    checkOutput("t1_ula_b", 8'(ula_b), 8'h01);
    applyStimulus(2'b00, 4'b1000, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0010);
    tick();
    checkOutput("t1_resp_valid", 8'(resp_valid), 8'h01);
    checkOutput("t1_resp_data", 8'(resp_data), 8'h00);
    checkOutput("t1_gnt_clear", 8'(gnt), 8'h00);
    checkOutput("t1_busy_clear", 8'(busy), 8'h00);

    // Requester 0 alone, NOR of 1111/0001 gives 00
    applyStimulus(2'b01, 4'b1000, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0010);
    tick();
    checkOutput("t2_gnt", 8'(gnt), 8'h01);
    applyStimulus(2'b00, 4'b1000, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0010);
    tick();
    checkOutput("t2_resp_valid", 8'(resp_valid), 8'h01);
    checkOutput("t2_resp_data", 8'(resp_data), 8'h00);
    checkOutput("t2_resp_err", 8'(resp_err), 8'h00);
    tick();
    checkOutput("t2_idle_gnt", 8'(gnt), 8'h00);
    checkOutput("t2_idle_resp_valid", 8'(resp_valid), 8'h00);

    // Both requesting continuously: last=0 so requester 1 goes first, then alternation
    applyStimulus(2'b11, 4'b1000, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0010);
    tick();
    checkOutput("t3_gnt_a", 8'(gnt), 8'h02);
    tick();
    checkOutput("t3_resp_a", 8'(resp_valid), 8'h02);
    checkOutput("t3_data_a", 8'(resp_data), 8'h03);
    tick();
    checkOutput("t3_gnt_b", 8'(gnt), 8'h01);
    tick();
    checkOutput("t3_resp_b", 8'(resp_valid), 8'h01);
    checkOutput("t3_data_b", 8'(resp_data), 8'h00);
    tick();
    checkOutput("t3_gnt_c", 8'(gnt), 8'h02);
    tick();
    checkOutput("t3_resp_c", 8'(resp_valid), 8'h02);
    checkOutput("t3_data_c", 8'(resp_data), 8'h03);
    tick();
    checkOutput("t3_gnt_d", 8'(gnt), 8'h01);
    tick();
    checkOutput("t3_resp_d", 8'(resp_valid), 8'h01);
    checkOutput("t3_data_d", 8'(resp_data), 8'h00);

    // Divide by zero from requester 1 is trapped
    applyStimulus(2'b10, 4'b1000, 4'b1111, 4'b0001, 4'b0011, 4'b0101, 4'b0000);
    tick();
    checkOutput("t4_gnt", 8'(gnt), 8'h02);
    checkOutput("t4_ula_sw", 8'(ula_switchs), 8'h03);
    applyStimulus(2'b00, 4'b1000, 4'b1111, 4'b0001, 4'b0011, 4'b0101, 4'b0000);
    tick();
    checkOutput("t4_resp_valid", 8'(resp_valid), 8'h02);
    checkOutput("t4_resp_data", 8'(resp_data), 8'h00);
    checkOutput("t4_resp_err", 8'(resp_err), 8'h01);
    applyStimulus(2'b10, 4'b1000, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0010);
    tick();
    checkOutput("t4_next_gnt", 8'(gnt), 8'h02);
    checkOutput("t4_err_held", 8'(resp_err), 8'h01);
    applyStimulus(2'b00, 4'b1000, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0010);
    tick();
    checkOutput("t4_next_resp_valid", 8'(resp_valid), 8'h02);
    checkOutput("t4_next_data", 8'(resp_data), 8'h03);
    checkOutput("t4_next_err", 8'(resp_err), 8'h00);

    // Reset during EXEC drops the op and restores last=1
    applyStimulus(2'b01, 4'b1000, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0010);
    tick();
    checkOutput("t5_gnt", 8'(gnt), 8'h01);
    checkOutput("t5_busy", 8'(busy), 8'h01);
    rst = 1'b1;
    applyStimulus(2'b00, 4'b1000, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0010);
    #1;
    checkOutput("t5_rst_gnt", 8'(gnt), 8'h00);
    checkOutput("t5_rst_busy", 8'(busy), 8'h00);
    checkOutput("t5_rst_data", 8'(resp_data), 8'h00);
    tick();
    checkOutput("t5_no_resp", 8'(resp_valid), 8'h00);
    #3;
    rst = 1'b0;
    applyStimulus(2'b11, 4'b1000, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0010);
    tick();
    checkOutput("t5_last_reset_gnt", 8'(gnt), 8'h01);
    applyStimulus(2'b00, 4'b1000, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0010);
    tick();
    checkOutput("t5_resp_after", 8'(resp_valid), 8'h01);

    // Operands changed during EXEC are ignored
    applyStimulus(2'b10, 4'b1000, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 4'b0010);
    tick();
    checkOutput("t6_gnt", 8'(gnt), 8'h02);
    applyStimulus(2'b00, 4'b1000, 4'b1111, 4'b0001, 4'b0100, 4'b0011, 4'b0011);
    #1;
    checkOutput("t6_ula_a_held", 8'(ula_a), 8'h01);
    checkOutput("t6_ula_sw_held", 8'(ula_switchs), 8'h00);
    tick();
    checkOutput("t6_resp_valid", 8'(resp_valid), 8'h02);
    checkOutput("t6_resp_data", 8'(resp_data), 8'h03);
    tick();
    checkOutput("t6_resp_pulse_end", 8'(resp_valid), 8'h00);
    checkOutput("t6_data_held", 8'(resp_data), 8'h03);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
